// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access size encoding, FSM states, latency ceiling.
// Pure declarations; no logic, no latency, no flow control.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rstate_t;

  localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/lane_merge.sv
// Store lane merge: builds the post-store word, lane enables and alignment flag for one access.
// Purely combinational, zero latency, no backpressure.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic [3:0]  lane_en_o,
  output logic        misalign_o
);

  logic [31:0] src;

  always_comb begin
    src        = wdata_i;
    lane_en_o  = 4'b0000;
    misalign_o = 1'b0;
    merged_o   = old_word_i;
    case (size_t'(size_i))
      SZ_WORD: begin
        lane_en_o  = 4'b1111;
        misalign_o = (addr_lo_i != 2'b00);
      end
      SZ_HALF: begin
        // Replicate the right-aligned data so either half-word lane pair can pick it up.
        src        = {2{wdata_i[15:0]}};
        lane_en_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      SZ_BYTE: begin
        src       = {4{wdata_i[7:0]}};
        lane_en_o = 4'b0001 << addr_lo_i;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (lane_en_o[i]) merged_o[8*i +: 8] = src[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory slave: response pulse LATENCY cycles after accept, sub-word stores merged here.
// req_ready is high only in IDLE, so one request is in flight and throughput is one per LATENCY+1 cycles.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Out-of-range LATENCY values are clamped into the supported 1..MAX_LATENCY window.
  localparam int LAT_EFF = (LATENCY < 1) ? 1 : ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
  localparam logic [3:0] CNT_LOAD = 4'(LAT_EFF - 1);

  rstate_t     state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] ram [DEPTH_WORDS];

  logic        accept;
  logic        access;
  logic [31:0] word_idx;
  logic [AW-1:0] ram_idx;
  logic        out_of_range;
  logic        misalign;
  logic        err;
  logic [31:0] old_word;
  logic [31:0] merged;
  logic [3:0]  lane_en;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LAT_EFF == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array is touched only on the edge entering RESP; reset on that edge drops the transaction.
  assign access = (state_d == RESP) && !reset;

  assign word_idx     = {2'b00, addr_q[31:2]};
  assign out_of_range = (word_idx >= 32'(DEPTH_WORDS));
  assign ram_idx      = addr_q[AW+1:2];
  assign old_word     = out_of_range ? 32'd0 : ram[ram_idx];
  assign err          = misalign | out_of_range | (size_t'(size_q) == SZ_ILL);

  lane_merge u_lane_merge (
    .old_word_i (old_word),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merged),
    .lane_en_o  (lane_en),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
      if (access) begin
        rdata_q <= err ? 32'd0 : old_word;
        err_q   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && wr_q && !err && (lane_en != 4'b0000)) begin
      ram[ram_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responder instances (LATENCY 2, 1, 5, 3) checked against hand-computed vectors.
module tb_dmem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst, rv, rw, rdy, rspv, rerr;
  logic [31:0] ra   [4];
  logic [31:0] wd   [4];
  logic [1:0]  rs   [4];
  logic [31:0] rdat [4];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (2048),
      .LATENCY     ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 3)
    ) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .req_valid  (rv[g]),
      .req_write  (rw[g]),
      .req_addr   (ra[g]),
      .req_wdata  (wd[g]),
      .req_size   (rs[g]),
      .req_ready  (rdy[g]),
      .resp_valid (rspv[g]),
      .resp_rdata (rdat[g]),
      .resp_err   (rerr[g])
    );
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        chk;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t vt[$];

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 5 : 3;
  endfunction

  task automatic check(string name, string what, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s,
                     logic chk, logic [31:0] rd, logic e);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.chk = chk; v.rd = rd; v.e = e;
    vt.push_back(v);
  endtask

  // Called #1 after an edge with instance k idle; returns #1 after the edge following its response.
  task automatic do_req(int k, logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s,
                        logic chk, logic [31:0] exp_rd, logic exp_e, string name);
    int   n;
    logic busy_high;
    busy_high = 1'b0;
    check(name, "ready_idle", 32'(rdy[k]), 32'd1);
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; wd[k] = d; rs[k] = s;
    step();
    rv[k] = 1'b0;
    n = 1;
    while (!rspv[k] && n < 20) begin
      if (rdy[k]) busy_high = 1'b1;
      step();
      n++;
    end
    check(name, "latency", 32'(n), 32'(lat_of(k)));
    check(name, "ready_busy", 32'(busy_high | rdy[k]), 32'd0);
    check(name, "err", 32'(rerr[k]), 32'(exp_e));
    if (chk) check(name, "rdata", rdat[k], exp_rd);
    step();
    check(name, "ready_back", 32'(rdy[k]), 32'd1);
    check(name, "resp_pulse", 32'(rspv[k]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   last [3];
    int   pulses [3];
    logic overlap [3];
    logic seen;

    rst = 4'hF; rv = 4'h0; rw = 4'h0;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 32'd0; wd[i] = 32'd0; rs[i] = SZ_WORD;
    end
    repeat (3) step();
    check("reset", "ready", 32'(rdy[0]), 32'd1);
    check("reset", "resp_valid", 32'(rspv[0]), 32'd0);
    check("reset", "rdata", rdat[0], 32'd0);
    check("reset", "err", 32'(rerr[0]), 32'd0);
    rst = 4'h0;

    // LATENCY = 2 functional vectors
    add(1, 32'h64,   32'h19,       SZ_WORD, 0, 32'h0,        0);
    add(0, 32'h64,   32'h0,        SZ_WORD, 1, 32'h19,       0);
    add(1, 32'h10,   32'h11223344, SZ_WORD, 0, 32'h0,        0);
    add(1, 32'h12,   32'hAB,       SZ_BYTE, 1, 32'h11223344, 0);
    add(0, 32'h10,   32'h0,        SZ_WORD, 1, 32'h11AB3344, 0);
    add(1, 32'h10,   32'hBEEF,     SZ_HALF, 1, 32'h11AB3344, 0);
    add(0, 32'h10,   32'h0,        SZ_WORD, 1, 32'h11ABBEEF, 0);
    add(1, 32'h11,   32'h1234,     SZ_HALF, 1, 32'h0,        1);
    add(0, 32'h12,   32'h0,        SZ_WORD, 1, 32'h0,        1);
    add(0, 32'h10,   32'h0,        SZ_WORD, 1, 32'h11ABBEEF, 0);
    add(0, 32'h2000, 32'h0,        SZ_WORD, 1, 32'h0,        1);
    add(0, 32'h10,   32'h0,        SZ_ILL,  1, 32'h0,        1);
    add(1, 32'h10,   32'h99999999, SZ_ILL,  1, 32'h0,        1);
    add(1, 32'h13,   32'hFFFFFF77, SZ_BYTE, 1, 32'h11ABBEEF, 0);
    add(0, 32'h10,   32'h0,        SZ_WORD, 1, 32'h77ABBEEF, 0);
    add(1, 32'h12,   32'h5555CAFE, SZ_HALF, 1, 32'h77ABBEEF, 0);
    add(0, 32'h12,   32'h0,        SZ_HALF, 1, 32'hCAFEBEEF, 0);
    add(0, 32'h11,   32'h0,        SZ_BYTE, 1, 32'hCAFEBEEF, 0);
    add(1, 32'h1FFC, 32'hA5A5A5A5, SZ_WORD, 0, 32'h0,        0);
    add(0, 32'h1FFC, 32'h0,        SZ_WORD, 1, 32'hA5A5A5A5, 0);
    add(1, 32'h4,    32'h0,        SZ_WORD, 0, 32'h0,        0);
    add(1, 32'h2004, 32'h1,        SZ_BYTE, 1, 32'h0,        1);
    add(0, 32'h4,    32'h0,        SZ_WORD, 1, 32'h0,        0);

    for (int i = 0; i < vt.size(); i++) begin
      do_req(0, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].chk, vt[i].rd, vt[i].e,
             $sformatf("vec%0d", i));
    end

    // LATENCY = 3: reset one cycle after accepting a store drops it
    do_req(3, 1, 32'h20, 32'h0, SZ_WORD, 0, 32'h0, 0, "rst_pre");
    rv[3] = 1'b1; rw[3] = 1'b1; ra[3] = 32'h20; wd[3] = 32'hDEADBEEF; rs[3] = SZ_WORD;
    step();
    rv[3] = 1'b0;
    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
    check("rst_mid", "ready_after_release", 32'(rdy[3]), 32'd1);
    seen = rspv[3];
    for (int c = 0; c < 6; c++) begin
      step();
      seen = seen | rspv[3];
    end
    check("rst_mid", "dropped_resp", 32'(seen), 32'd0);
    do_req(3, 0, 32'h20, 32'h0, SZ_WORD, 1, 32'h0, 0, "rst_load");

    // LATENCY = 1 and 5 with req_valid held high back to back
    for (int j = 0; j < 3; j++) begin
      last[j] = -1; pulses[j] = 0; overlap[j] = 1'b0;
    end
    for (int k = 1; k < 3; k++) begin
      rw[k] = 1'b0; ra[k] = 32'h0; rs[k] = SZ_WORD; rv[k] = 1'b1;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      for (int k = 1; k < 3; k++) begin
        if (rdy[k] && rspv[k]) overlap[k] = 1'b1;
        if (rspv[k]) begin
          if (last[k] >= 0)
            check($sformatf("b2b_lat%0d", lat_of(k)), "spacing", 32'(cyc - last[k]),
                  32'(lat_of(k) + 1));
          last[k] = cyc;
          pulses[k]++;
        end
      end
    end
    rv[1] = 1'b0; rv[2] = 1'b0;
    check("b2b_lat1", "enough_pulses", 32'(pulses[1] >= 5), 32'd1);
    check("b2b_lat5", "enough_pulses", 32'(pulses[2] >= 5), 32'd1);
    check("b2b_lat1", "ready_with_resp", 32'(overlap[1]), 32'd0);
    check("b2b_lat5", "ready_with_resp", 32'(overlap[2]), 32'd0);
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder: the memory-side end of the core's load/store interface. It replaces the zero-latency dmem with a request/response slave that has fixed latency and performs sub-word stores internally (lane merge). It returns the raw 32-bit word; the core's load-extend path stays in the core. While a request is outstanding the responder deasserts req_ready, and the core uses that as its stall (PCReady) source.

Parameters:
DEPTH_WORDS, 2048, number of 32-bit words in the array; word index = req_addr[31:2].
LATENCY, 2, cycles from accept edge to the response cycle; legal range 1..15.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  initiator has a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  00 word, 01 half, 10 byte, 11 illegal (same encoding as core loadcontrol)
req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready at a rising edge
resp_valid  output  1  one-cycle pulse marking response cycle
resp_rdata  output  32  full word at aligned address (pre-write contents for stores)
resp_err  output  1  valid with resp_valid; misaligned, illegal size or out of range

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On accept, latch write/addr/wdata/size and load cnt = LATENCY-1. Go to RESP if LATENCY = 1, else WAIT.
- WAIT: req_ready = 0. cnt decrements each cycle; when cnt = 1 the next state is RESP. resp_valid is therefore first high exactly LATENCY cycles after the accept edge.
- RESP: resp_valid = 1, req_ready = 0. Next state is IDLE unconditionally. Maximum throughput is one request per LATENCY+1 cycles.
- Array access happens on the edge entering RESP:
  - resp_rdata and resp_err are registered on that edge.
  - A store is committed on the same edge.
  - A load issued on the next accept sees the stored data.
- Lane enables for stores:
  - word: all four lanes.
  - half: lanes {1,0} if addr[1] = 0, else lanes {3,2}, written with wdata[15:0].
  - byte: lane addr[1:0], written with wdata[7:0].
  - Disabled lanes keep their old value.
- Error condition (resp_err = 1): any of
  - half access with addr[0] = 1,
  - word access with addr[1:0] != 0,
  - size = 11,
  - addr[31:2] >= DEPTH_WORDS.
  On error: no write occurs, resp_rdata = 0.
- Request fields are ignored while req_ready = 0; the initiator holds them stable until accepted.
- Reset values: state IDLE, req_ready = 1 (the first cycle after reset release accepts), resp_valid = 0, resp_rdata = 0, resp_err = 0, cnt = 0.
- Array contents are not reset. The array is preloadable by $readmemh on the array instance (RAM).
- Reset mid-operation (in WAIT or RESP): the pending transaction is dropped.
  - A store not yet committed is never written.
  - No resp_valid pulse is produced for it.
- cnt width is 4 bits. No wrap-around is possible within the legal LATENCY range.
- Addresses wrap only via truncation to [31:2]; the range check catches indices beyond DEPTH_WORDS.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] size_t {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_ILL = 2'b11};
  - typedef enum logic [1:0] rstate_t {IDLE, WAIT, RESP};
  - constant MAX_LATENCY = 15.
- One sub-module, lane_merge: combinational.
  - Inputs: old word, req_wdata, req_size, addr[1:0].
  - Outputs: merged word, 4-bit lane enable, misalign flag.
- The top level holds the FSM, the counter, the array and the registered response.

Test Plan:
- Reset, then word store to 0x64 with data 0x00000019, then word load of 0x64 (LATENCY = 2) -> store response at cycle accept+2 with resp_err = 0; load resp_rdata = 0x00000019 at its accept+2; req_ready low for exactly 2 cycles per request.
- Preload 0x11223344 at 0x10; byte store 0xAB to 0x12; word load 0x10 -> 0x11AB3344. Then half store 0xBEEF to 0x10; load -> 0x11ABBEEF.
- Misaligned half store to 0x11 and word load from 0x12 -> resp_err = 1, resp_rdata = 0, word at 0x10 unchanged.
- Out-of-range word load at 0x2000 with DEPTH_WORDS = 2048, and req_size = 11 -> resp_err = 1 for both.
- LATENCY = 1 and LATENCY = 5 builds, back-to-back req_valid held high -> resp_valid spacing of 2 and 6 cycles respectively; req_ready never high in the same cycle as resp_valid.
- Word store of 0xDEADBEEF to 0x20 while 0x20 holds 0x0, with reset asserted in the cycle after accept (LATENCY = 3) -> no resp_valid; a subsequent load of 0x20 returns 0x00000000; req_ready = 1 on the first cycle after reset release.
